input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter COUNTER_WIDTH, default 3, giving the debounce counter width in bits.
REQ-002 The block SHALL have parameter WAIT_TIME, default 3, giving the cycles a synchronized input must differ from the conditioned value before it is accepted.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports noisy_a and noisy_b, input, 1 bit each: raw asynchronous switch inputs.
REQ-006 The block SHALL have ports conditioned_a and conditioned_b, output, 1 bit each: debounced levels that drive the downstream gate stage's A and B inputs.
REQ-007 The block SHALL have ports positiveedge_a and positiveedge_b, output, 1 bit each: one-cycle pulse when the conditioned level rises.
REQ-008 The block SHALL have ports negativeedge_a and negativeedge_b, output, 1 bit each: one-cycle pulse when the conditioned level falls.

Function
REQ-009 Each channel SHALL be independent and identical; channel A and channel B SHALL never share state.
REQ-010 Each channel SHALL pass its noisy input through a two-flop synchronizer: sync0 <= noisy, then sync1 <= sync0.
REQ-011 Each channel SHALL hold a counter of COUNTER_WIDTH bits and a registered conditioned level.
REQ-012 When sync1 equals conditioned, the channel SHALL clear counter to 0 and hold conditioned.
REQ-013 When sync1 differs from conditioned and counter < WAIT_TIME, the channel SHALL increment counter by 1 and hold conditioned.
REQ-014 When sync1 differs from conditioned and counter == WAIT_TIME, the channel SHALL load conditioned <= sync1 and clear counter to 0 in the same cycle.
REQ-015 In the cycle conditioned loads 1 per REQ-014, the channel SHALL assert positiveedge for exactly one clock; it SHALL be 0 in all other cycles.
REQ-016 In the cycle conditioned loads 0 per REQ-014, the channel SHALL assert negativeedge for exactly one clock; it SHALL be 0 in all other cycles.
REQ-017 positiveedge and negativeedge of one channel SHALL never be asserted in the same cycle, and each SHALL be registered and aligned with the conditioned change.
REQ-018 A noisy level held stable SHALL appear on conditioned exactly WAIT_TIME+3 rising edges after the first edge that samples it (2 synchronizer edges, WAIT_TIME count edges, 1 load edge); for default parameters this is 6 edges.
REQ-019 Any return of sync1 to the conditioned value before the load SHALL clear counter, so pulses of fewer than WAIT_TIME+1 cycles at sync1 SHALL be rejected with no output or edge activity.
REQ-020 The counter SHALL never exceed WAIT_TIME and SHALL never wrap.
REQ-021 WAIT_TIME SHALL be at most 2^COUNTER_WIDTH - 1; an elaboration-time check SHALL flag any violation.
REQ-022 Simultaneous transitions on both channels SHALL be processed concurrently with identical latency.

Reset
REQ-023 While reset is high at a rising clk edge, the block SHALL clear sync0, sync1, counter, conditioned, positiveedge and negativeedge of both channels to 0.
REQ-024 A reset asserted mid-count SHALL abandon the pending transition; no edge pulse SHALL be emitted for it.
REQ-025 After reset deasserts, a noisy input already high SHALL be treated as a fresh transition and SHALL produce positiveedge per REQ-018.

Structure
REQ-026 The default values of WAIT_TIME and COUNTER_WIDTH SHALL reside in the shared project constants include, used by this block and its bench.
REQ-027 The per-channel logic SHALL be a sub-module named conditioner_channel, instantiated twice by input_conditioner, with ports clk, reset, noisy, conditioned, positiveedge and negativeedge.

Verification
REQ-028 The bench SHALL cover clean rise: reset 2 cycles, noisy_a 0->1 held -> conditioned_a=1 on edge 6, positiveedge_a high for that one cycle only.
REQ-029 The bench SHALL cover glitch reject: noisy_b high for 2 cycles, then 0 -> conditioned_b stays 0, no edge pulses, counter back to 0.
REQ-030 The bench SHALL cover bounce: noisy_a toggling 1,0,1,0,1 per cycle then held 1 -> single positiveedge_a, 6 edges after the final stable sample.
REQ-031 The bench SHALL cover clean fall: conditioned_a=1, noisy_a 1->0 held -> conditioned_a=0 after 6 edges, one negativeedge_a pulse, no positiveedge_a.
REQ-032 The bench SHALL cover mid-count reset: reset asserted at counter=2 -> all outputs 0 next edge, no pulse; noisy still 1 -> positiveedge 6 edges after reset release.
REQ-033 The bench SHALL cover concurrency: noisy_a and noisy_b rising on the same edge -> both conditioned outputs and both positiveedge pulses in the same cycle.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helper types for the two-channel switch input conditioner.
// The debounce defaults live here so the block and its bench agree on them.
package input_conditioner_pkg;

    localparam int DEFAULT_COUNTER_WIDTH = 3;
    localparam int DEFAULT_WAIT_TIME     = 3;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_COUNT = 2'd1,
        ACT_LOAD  = 2'd2
    } condAction_e;

    // A synchronized level must persist past the count limit before it is accepted.
    function automatic condAction_e nextAction(input logic syncLevel,
                                               input logic condLevel,
                                               input logic atLimit);
        condAction_e action;
        action = ACT_HOLD;
        if (syncLevel != condLevel) begin
            action = atLimit ? ACT_LOAD : ACT_COUNT;
        end
        return action;
    endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One debounce channel: two-flop synchronizer, persistence counter, registered
// conditioned level with one-cycle rise/fall pulses aligned to the level change.
module conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int WAIT_TIME     = DEFAULT_WAIT_TIME
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    localparam logic [COUNTER_WIDTH-1:0] LP_WAIT = COUNTER_WIDTH'(WAIT_TIME);

    if ((WAIT_TIME < 0) || (WAIT_TIME > (2 ** COUNTER_WIDTH) - 1)) begin : g_badWaitTime
        $error("conditioner_channel: WAIT_TIME %0d does not fit in COUNTER_WIDTH %0d bits",
               WAIT_TIME, COUNTER_WIDTH);
    end

    logic                     r_sync0;
    logic                     r_sync1;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_conditioned;
    logic                     r_posEdge;
    logic                     r_negEdge;
    condAction_e              w_action;

    always_comb begin
        w_action = nextAction(r_sync1, r_conditioned, (r_count == LP_WAIT));
    end

    // Edge pulses default low every cycle and are only raised on the load cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0       <= 1'b0;
            r_sync1       <= 1'b0;
            r_count       <= '0;
            r_conditioned <= 1'b0;
            r_posEdge     <= 1'b0;
            r_negEdge     <= 1'b0;
        end else begin
            r_sync0   <= noisy;
            r_sync1   <= r_sync0;
            r_posEdge <= 1'b0;
            r_negEdge <= 1'b0;
            case (w_action)
                ACT_COUNT: begin
                    r_count <= r_count + COUNTER_WIDTH'(1);
                end
                ACT_LOAD: begin
                    r_count       <= '0;
                    r_conditioned <= r_sync1;
                    r_posEdge     <= r_sync1;
                    r_negEdge     <= ~r_sync1;
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_count <= LP_WAIT);
        end
    end

    assign conditioned  = r_conditioned;
    assign positiveedge = r_posEdge;
    assign negativeedge = r_negEdge;

endmodule

// File: rtl/input_conditioner.sv
// Two independent debounce channels feeding the downstream gate stage's A and B inputs.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int WAIT_TIME     = DEFAULT_WAIT_TIME
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy_a,
    input  logic noisy_b,
    output logic conditioned_a,
    output logic conditioned_b,
    output logic positiveedge_a,
    output logic positiveedge_b,
    output logic negativeedge_a,
    output logic negativeedge_b
);

    conditioner_channel #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .WAIT_TIME     (WAIT_TIME)
    ) u_chan_a (
        .clk          (clk),
        .reset        (reset),
        .noisy        (noisy_a),
        .conditioned  (conditioned_a),
        .positiveedge (positiveedge_a),
        .negativeedge (negativeedge_a)
    );

    conditioner_channel #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .WAIT_TIME     (WAIT_TIME)
    ) u_chan_b (
        .clk          (clk),
        .reset        (reset),
        .noisy        (noisy_b),
        .conditioned  (conditioned_b),
        .positiveedge (positiveedge_b),
        .negativeedge (negativeedge_b)
    );

endmodule
